rd_req_arbiter: RTL and testbench

- Shares the single AXI burst-read request channel (rd_req / rd_len / rd_address / rd_req_ack) among N_REQ io_control instances, one per decompressor engine.
- Arbitration is per burst, round-robin. Each granted request is latched and presented downstream until acknowledged.
- Emits the granted requester index as rd_id so the read-data return path can route responses.

---
 rtl/rd_req_arbiter.sv | 132 +++++++++++++
 tb/tb_rd_req_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/rd_req_arbiter.sv
// Round-robin, per-burst arbiter that shares one AXI burst-read request channel
// among N_REQ requesters. The granted index goes out as rd_id for response routing.

module rd_req_arb_lane #(
  parameter int ID_W = 2,
  parameter int IDX  = 0
) (
  input  logic            gnt_ack,
  input  logic [ID_W-1:0] rd_id,
  output logic            ack
);
  assign ack = gnt_ack && (rd_id == ID_W'(IDX));
endmodule

module rd_req_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ID_W   = 2,
  parameter int ADDR_W = 64,
  parameter int LEN_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ*LEN_W-1:0]  len_i,
  input  logic [N_REQ*ADDR_W-1:0] addr_i,
  output logic [N_REQ-1:0]        ack_o,
  output logic                    rd_req,
  output logic [LEN_W-1:0]        rd_len,
  output logic [ADDR_W-1:0]       rd_address,
  output logic [ID_W-1:0]         rd_id,
  input  logic                    rd_req_ack,
  output logic                    busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                         state, state_nx;
  logic [ID_W-1:0]                last_gnt;
  logic [N_REQ-1:0][LEN_W-1:0]    len_a;
  logic [N_REQ-1:0][ADDR_W-1:0]   addr_a;
  logic                           hi_vld, lo_vld, sel_vld, load;
  logic [ID_W-1:0]                hi_idx, lo_idx, sel_idx;
  logic [LEN_W-1:0]               nx_len;
  logic [ADDR_W-1:0]              nx_addr;
  logic                           gnt_ack;

  assign len_a  = len_i;
  assign addr_a = addr_i;

  // Circular search from last_gnt+1: lowest requester above last_gnt wins,
  // otherwise wrap to the lowest requester at or below it.
  always_comb begin
    hi_vld = 1'b0;
    lo_vld = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        if (i > int'(last_gnt)) begin
          hi_vld = 1'b1;
          hi_idx = ID_W'(i);
        end else begin
          lo_vld = 1'b1;
          lo_idx = ID_W'(i);
        end
      end
    end
    sel_vld = hi_vld || lo_vld;
    sel_idx = hi_vld ? hi_idx : lo_idx;
  end

  always_comb begin
    nx_len  = '0;
    nx_addr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (sel_idx == ID_W'(i)) begin
        nx_len  = len_a[i];
        nx_addr = addr_a[i];
      end
    end
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    case (state)
      IDLE: begin
        if (en && sel_vld) begin
          state_nx = GRANT;
          load     = 1'b1;
        end
      end
      GRANT: begin
        if (rd_req_ack) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_gnt   <= ID_W'(N_REQ - 1);
      rd_id      <= '0;
      rd_len     <= '0;
      rd_address <= '0;
    end else begin
      state <= state_nx;
      if (load) begin
        last_gnt   <= sel_idx;
        rd_id      <= sel_idx;
        rd_len     <= nx_len;
        rd_address <= nx_addr;
      end
    end
  end

  // rd_req and busy come straight from the state flop: no input-to-output path.
  assign rd_req  = (state == GRANT);
  assign busy    = (state == GRANT);
  assign gnt_ack = rd_req_ack && (state == GRANT) && !rst;

  for (genvar g = 0; g < N_REQ; g++) begin : g_lane
    rd_req_arb_lane #(.ID_W(ID_W), .IDX(g)) u_lane (
      .gnt_ack (gnt_ack),
      .rd_id   (rd_id),
      .ack     (ack_o[g])
    );
  end

endmodule

// File: tb/tb_rd_req_arbiter.sv
// Directed bench for rd_req_arbiter: a cycle model of the arbitration rules checked
// every cycle, plus hand-computed expectations for each scenario.

module tb_rd_req_arbiter;
  localparam int N = 4;

  logic          clk, rst, en;
  logic [3:0]    req_i;
  logic [31:0]   len_i;
  logic [255:0]  addr_i;
  logic [3:0]    ack_o;
  logic          rd_req, rd_req_ack, busy;
  logic [7:0]    rd_len;
  logic [63:0]   rd_address;
  logic [1:0]    rd_id;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 0;

  rd_req_arbiter #(.N_REQ(4), .ID_W(2), .ADDR_W(64), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .req_i(req_i), .len_i(len_i), .addr_i(addr_i),
    .ack_o(ack_o), .rd_req(rd_req), .rd_len(rd_len), .rd_address(rd_address),
    .rd_id(rd_id), .rd_req_ack(rd_req_ack), .busy(busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: one outstanding burst, owner chosen circularly after the last owner.
  logic        m_busy;
  logic [1:0]  m_id;
  int          m_last;
  logic [7:0]  m_len;
  logic [63:0] m_addr;

  function automatic int pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= N; k++)
      if (r[(last + k) % N]) return (last + k) % N;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 0; m_id <= 0; m_last <= N - 1; m_len <= 0; m_addr <= 0;
    end else if (m_busy) begin
      if (rd_req_ack) m_busy <= 0;
    end else if (en && req_i != 0) begin
      m_busy <= 1;
      m_id   <= 2'(pick(req_i, m_last));
      m_last <= pick(req_i, m_last);
      m_len  <= len_i[pick(req_i, m_last)*8 +: 8];
      m_addr <= addr_i[pick(req_i, m_last)*64 +: 64];
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("m_rd_req", rd_req, m_busy);
      chk("m_busy", busy, m_busy);
      chk("m_rd_id", rd_id, m_id);
      chk("m_rd_len", rd_len, m_len);
      chk("m_rd_address", rd_address, m_addr);
      chk("m_ack_o", ack_o, (rd_req_ack && m_busy && !rst) ? (4'b0001 << m_id) : 4'b0000);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_rq(input int i, input logic [63:0] a, input logic [7:0] l);
    addr_i[i*64 +: 64] = a;
    len_i[i*8 +: 8]    = l;
  endtask

  task automatic do_reset();
    rst = 1; tick(); rst = 0;
  endtask

  task automatic wait_rq(input string nm);
    int n = 0;
    while (rd_req !== 1'b1 && n < 10) begin tick(); n++; end
    chk(nm, rd_req, 1);
  endtask

  // Wait for a grant, check its owner, ack it after dly cycles and check ack_o.
  task automatic burst(input string nm, input int exp_id, input int dly);
    wait_rq({nm, "_req"});
    chk({nm, "_id"}, rd_id, exp_id);
    repeat (dly) tick();
    rd_req_ack = 1; #1;
    chk({nm, "_ack"}, ack_o, 4'b0001 << exp_id);
    tick();
    rd_req_ack = 0;
    chk({nm, "_gap"}, rd_req, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int ids2[6] = '{0, 1, 2, 3, 0, 1};
    rst = 1; en = 0; req_i = 0; len_i = 0; addr_i = 0; rd_req_ack = 0;
    tick(); cmp_on = 1; tick();
    chk("rst_rd_req", rd_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_id", rd_id, 0);
    chk("rst_ack_o", ack_o, 0);
    rst = 0;

    // 1: single requester, ack 3 cycles after rd_req, address advances on ack
    en = 1; set_rq(0, 64'h1000, 8'h3F); req_i = 4'b0001;
    tick();
    chk("t1_rd_req", rd_req, 1);
    chk("t1_addr", rd_address, 64'h1000);
    chk("t1_len", rd_len, 8'h3F);
    chk("t1_id", rd_id, 0);
    tick(); tick(); tick();
    rd_req_ack = 1; #1;
    chk("t1_ack_o", ack_o, 4'b0001);
    tick();
    rd_req_ack = 0; set_rq(0, 64'h2000, 8'h3F);
    chk("t1_gap", rd_req, 0);
    tick();
    chk("t1_rereq", rd_req, 1);
    chk("t1_addr2", rd_address, 64'h2000);
    rd_req_ack = 1; tick(); rd_req_ack = 0; req_i = 0; tick();

    // 2: all four requesting continuously
    do_reset();
    for (int i = 0; i < 4; i++) set_rq(i, 64'h10000 + 64'(i) * 64'h100, 8'(i + 1));
    req_i = 4'b1111;
    for (int k = 0; k < 6; k++) burst($sformatf("t2_%0d", k), ids2[k], 1);
    req_i = 0; tick();

    // 3: requesters 1 and 3, after a grant to 1
    do_reset();
    req_i = 4'b0010;
    burst("t3_a", 1, 0);
    req_i = 4'b1010;
    burst("t3_b", 3, 0);
    burst("t3_c", 1, 0);
    req_i = 0; tick();

    // 4: owner's addr/len churn while granted
    do_reset();
    set_rq(0, 64'hA000, 8'h10); req_i = 4'b0001;
    wait_rq("t4_req");
    for (int k = 0; k < 4; k++) begin
      set_rq(0, 64'hB000 + 64'(k), 8'(k));
      tick();
      chk("t4_addr", rd_address, 64'hA000);
      chk("t4_len", rd_len, 8'h10);
    end
    rd_req_ack = 1; tick(); rd_req_ack = 0; req_i = 0; tick();

    // 5: spurious ack in IDLE, then en dropped mid-burst
    rd_req_ack = 1; #1;
    chk("t5_spur_ack", ack_o, 0);
    tick(); rd_req_ack = 0;
    chk("t5_spur_req", rd_req, 0);
    chk("t5_spur_busy", busy, 0);
    set_rq(2, 64'hC000, 8'h07); req_i = 4'b0100;
    wait_rq("t5_req");
    chk("t5_id", rd_id, 2);
    en = 0; tick();
    rd_req_ack = 1; #1;
    chk("t5_ack_o", ack_o, 4'b0100);
    tick(); rd_req_ack = 0;
    repeat (3) begin chk("t5_hold", rd_req, 0); tick(); end
    en = 1; tick();
    chk("t5_resume", rd_req, 1);
    chk("t5_resume_id", rd_id, 2);

    // 6: reset together with ack during GRANT
    req_i = 4'b1111;
    rst = 1; rd_req_ack = 1; #1;
    chk("t6_ack_o", ack_o, 0);
    tick(); rst = 0; rd_req_ack = 0;
    chk("t6_rd_req", rd_req, 0);
    chk("t6_busy", busy, 0);
    chk("t6_rd_id", rd_id, 0);
    tick();
    chk("t6_first_req", rd_req, 1);
    chk("t6_first_id", rd_id, 0);
    req_i = 0; rd_req_ack = 1; tick(); rd_req_ack = 0; tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
